// File: rtl/top.sv
`default_nettype none
// ============================================================================
// Module      : top
// Description : Sum-of-squares engine. One start token on arg0 launches a
//               loop computing sum(i*i) for i = 0 .. LOOP_COUNT-1 (mod 2^32).
//               The result leaves on out0 and a completion token leaves on
//               outCtrl; both use valid/ready and handshake independently.
//
//               Ports:
//                 clock          - single clock, rising-edge active
//                 reset          - asynchronous, active-high reset
//                 arg0_valid     - start token offered (no payload)
//                 arg0_ready     - start token can be accepted (IDLE only)
//                 out0_valid     - result token valid
//                 out0_ready     - consumer accepts result
//                 out0_data[31:0]- result value (holds accumulator always)
//                 outCtrl_valid  - completion token valid
//                 outCtrl_ready  - consumer accepts completion token
//
//               Build option:
//                 TOP_CTRL_SYNC_EN - when defined, outCtrl_valid is raised
//                 only in the cycle after the out0 transfer, so the result
//                 always leaves before the completion token.
//
// Revision    : 1.0 - initial release
// ============================================================================
module top #(
    parameter int unsigned LOOP_COUNT = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arg0_valid,
    output logic        arg0_ready,
    output logic        out0_valid,
    input  logic        out0_ready,
    output logic [31:0] out0_data,
    output logic        outCtrl_valid,
    input  logic        outCtrl_ready
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Index of the final iteration; wraps for a zero-length loop, but RUN is
    // never entered in that case.
    localparam logic [31:0] c_LAST_IDX  = 32'(LOOP_COUNT) - 32'd1;
    localparam bit          c_ZERO_LOOP = (LOOP_COUNT == 0);

`ifdef TOP_CTRL_SYNC_EN
    localparam bit c_CTRL_SYNC = 1'b1;
`else
    localparam bit c_CTRL_SYNC = 1'b0;
`endif

    logic [1:0]  r_state;
    logic [31:0] r_i;
    logic [31:0] r_acc;
    logic        r_out0_valid;
    logic        r_ctrl_valid;

    logic [31:0] w_sq;
    logic        w_out0_fire;
    logic        w_ctrl_fire;
    logic        w_done_exit;

    // Ready is gated by reset so it reads 0 during reset yet is already 1 in
    // the first cycle after release, letting a held token in at that edge.
    assign arg0_ready    = (r_state == c_IDLE) && !reset;
    assign out0_valid    = r_out0_valid;
    assign outCtrl_valid = r_ctrl_valid;
    assign out0_data     = r_acc;

    assign w_sq        = r_i * r_i;
    assign w_out0_fire = r_out0_valid && out0_ready;
    assign w_ctrl_fire = r_ctrl_valid && outCtrl_ready;

    // In ordered mode the completion token is always last, so its transfer
    // alone ends DONE. Otherwise each side is finished once its valid is low
    // or it is transferring in this cycle.
    assign w_done_exit = c_CTRL_SYNC ? w_ctrl_fire
                                     : ((!r_out0_valid || out0_ready) &&
                                        (!r_ctrl_valid || outCtrl_ready));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_i          <= 32'd0;
            r_acc        <= 32'd0;
            r_out0_valid <= 1'b0;
            r_ctrl_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (arg0_valid) begin
                        r_i   <= 32'd0;
                        r_acc <= 32'd0;
                        if (c_ZERO_LOOP) begin
                            r_state      <= c_DONE;
                            r_out0_valid <= 1'b1;
                            r_ctrl_valid <= !c_CTRL_SYNC;
                        end else begin
                            r_state <= c_RUN;
                        end
                    end
                end

                c_RUN: begin
                    r_acc <= r_acc + w_sq;
                    r_i   <= r_i + 32'd1;
                    if (r_i == c_LAST_IDX) begin
                        r_state      <= c_DONE;
                        r_out0_valid <= 1'b1;
                        r_ctrl_valid <= !c_CTRL_SYNC;
                    end
                end

                c_DONE: begin
                    if (w_out0_fire) begin
                        r_out0_valid <= 1'b0;
                    end
                    // Ordered mode: completion token appears the cycle after
                    // the result has gone.
                    if (c_CTRL_SYNC && w_out0_fire) begin
                        r_ctrl_valid <= 1'b1;
                    end
                    if (w_ctrl_fire) begin
                        r_ctrl_valid <= 1'b0;
                    end
                    if (w_done_exit) begin
                        r_state <= c_IDLE;
                    end
                end

                default: begin
                    r_state      <= c_IDLE;
                    r_out0_valid <= 1'b0;
                    r_ctrl_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_top
// Description : Self-checking bench for top. Four instances with LOOP_COUNT
//               10, 1, 0 and 4 share clock and reset. A vector table drives
//               single tokens through each instance; hand-written sequences
//               cover reset hand-over, back-pressure, reset during RUN and
//               back-to-back tokens. Follows TOP_CTRL_SYNC_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid [4];
    logic        a_ready [4];
    logic        o_valid [4];
    logic        o_ready [4];
    logic [31:0] o_data  [4];
    logic        c_valid [4];
    logic        c_ready [4];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    top #(.LOOP_COUNT(10)) u_dut10 (
        .clock(clock), .reset(reset),
        .arg0_valid(a_valid[0]), .arg0_ready(a_ready[0]),
        .out0_valid(o_valid[0]), .out0_ready(o_ready[0]), .out0_data(o_data[0]),
        .outCtrl_valid(c_valid[0]), .outCtrl_ready(c_ready[0]));

    top #(.LOOP_COUNT(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .arg0_valid(a_valid[1]), .arg0_ready(a_ready[1]),
        .out0_valid(o_valid[1]), .out0_ready(o_ready[1]), .out0_data(o_data[1]),
        .outCtrl_valid(c_valid[1]), .outCtrl_ready(c_ready[1]));

    top #(.LOOP_COUNT(0)) u_dut0 (
        .clock(clock), .reset(reset),
        .arg0_valid(a_valid[2]), .arg0_ready(a_ready[2]),
        .out0_valid(o_valid[2]), .out0_ready(o_ready[2]), .out0_data(o_data[2]),
        .outCtrl_valid(c_valid[2]), .outCtrl_ready(c_ready[2]));

    top #(.LOOP_COUNT(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .arg0_valid(a_valid[3]), .arg0_ready(a_ready[3]),
        .out0_valid(o_valid[3]), .out0_ready(o_ready[3]), .out0_data(o_data[3]),
        .outCtrl_valid(c_valid[3]), .outCtrl_ready(c_ready[3]));

    typedef struct {
        int          k;
        int          lat;
        logic [31:0] data;
        string       name;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offers a token on instance k, waits for its result and checks the RUN
    // length and result. Returns at the first negedge with out0_valid high.
    task automatic start_token(input int k, input int lat, input logic [31:0] data,
                               input string name);
        int  n;
        bit  ready_ok;
        a_valid[k] = 1'b1;
        n = 0;
        while (!a_ready[k] && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({name, " accept"}, 32'(a_ready[k]), 32'd1);
        @(negedge clock);
        a_valid[k] = 1'b0;
        n = 0;
        ready_ok = 1'b1;
        while (!o_valid[k] && n < 200) begin
            if (a_ready[k]) ready_ok = 1'b0;
            @(negedge clock);
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(lat));
        check({name, " busy_ready"}, 32'(ready_ok), 32'd1);
        check({name, " data"}, o_data[k], data);
    endtask

    // Completes the DONE phase with both readies high.
    task automatic finish_done(input int k, input string name);
`ifdef TOP_CTRL_SYNC_EN
        check({name, " ctrl_before"}, 32'(c_valid[k]), 32'd0);
        @(negedge clock);
        check({name, " out0_gone"}, 32'(o_valid[k]), 32'd0);
        check({name, " ctrl_rise"}, 32'(c_valid[k]), 32'd1);
        @(negedge clock);
        check({name, " ctrl_gone"}, 32'(c_valid[k]), 32'd0);
        check({name, " idle_ready"}, 32'(a_ready[k]), 32'd1);
`else
        check({name, " ctrl_valid"}, 32'(c_valid[k]), 32'd1);
        @(negedge clock);
        check({name, " out0_gone"}, 32'(o_valid[k]), 32'd0);
        check({name, " ctrl_gone"}, 32'(c_valid[k]), 32'd0);
        check({name, " idle_ready"}, 32'(a_ready[k]), 32'd1);
`endif
    endtask

    initial begin
        int bad;
        int acc_n, out_n, cyc, first_acc, second_acc, period;
        bit drop;

        vecs[0] = '{k: 0, lat: 10, data: 32'd285, name: "lc10"};
        vecs[1] = '{k: 1, lat: 1,  data: 32'd0,   name: "lc1"};
        vecs[2] = '{k: 2, lat: 0,  data: 32'd0,   name: "lc0"};
        vecs[3] = '{k: 3, lat: 4,  data: 32'd14,  name: "lc4"};
        vecs[4] = '{k: 0, lat: 10, data: 32'd285, name: "lc10_again"};

        for (int j = 0; j < 4; j++) begin
            a_valid[j] = 1'b0;
            o_ready[j] = 1'b1;
            c_ready[j] = 1'b1;
        end
        reset      = 1'b1;
        a_valid[0] = 1'b1;   // token held across reset
        repeat (3) @(negedge clock);

        check("rst arg0_ready", 32'(a_ready[0]), 32'd0);
        check("rst out0_valid", 32'(o_valid[0]), 32'd0);
        check("rst ctrl_valid", 32'(c_valid[0]), 32'd0);
        check("rst out0_data", o_data[0], 32'd0);

        reset = 1'b0;
        #1;
        check("post_rst arg0_ready", 32'(a_ready[0]), 32'd1);
        start_token(0, 10, 32'd285, "por");
        finish_done(0, "por");

        for (int v = 0; v < 5; v++) begin
            @(negedge clock);
            start_token(vecs[v].k, vecs[v].lat, vecs[v].data, vecs[v].name);
            finish_done(vecs[v].k, vecs[v].name);
        end

        // Back-pressure on out0 only.
        @(negedge clock);
        o_ready[0] = 1'b0;
        start_token(0, 10, 32'd285, "bp");
`ifndef TOP_CTRL_SYNC_EN
        check("bp ctrl_valid", 32'(c_valid[0]), 32'd1);
`endif
        for (int t = 0; t < 5; t++) begin
            @(negedge clock);
            check("bp out0_hold", 32'(o_valid[0]), 32'd1);
            check("bp data_hold", o_data[0], 32'd285);
            check("bp not_idle", 32'(a_ready[0]), 32'd0);
            check("bp ctrl_state", 32'(c_valid[0]), 32'd0);
        end
        o_ready[0] = 1'b1;
        @(negedge clock);
        check("bp out0_gone", 32'(o_valid[0]), 32'd0);
`ifdef TOP_CTRL_SYNC_EN
        check("bp ctrl_rise", 32'(c_valid[0]), 32'd1);
        check("bp still_busy", 32'(a_ready[0]), 32'd0);
        @(negedge clock);
        check("bp ctrl_gone", 32'(c_valid[0]), 32'd0);
`endif
        check("bp idle_ready", 32'(a_ready[0]), 32'd1);

        // Reset during the fifth RUN cycle aborts the token.
        @(negedge clock);
        a_valid[0] = 1'b1;
        @(negedge clock);
        a_valid[0] = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst arg0_ready", 32'(a_ready[0]), 32'd0);
        check("midrst out0_valid", 32'(o_valid[0]), 32'd0);
        check("midrst out0_data", o_data[0], 32'd0);
        @(negedge clock);
        reset = 1'b0;
        bad = 0;
        for (int t = 0; t < 15; t++) begin
            if (o_valid[0] || c_valid[0]) bad++;
            @(negedge clock);
        end
        check("midrst no_output", 32'(bad), 32'd0);
        start_token(0, 10, 32'd285, "after_rst");
        finish_done(0, "after_rst");

        // Back-to-back tokens with arg0_valid held high.
        @(negedge clock);
        a_valid[0] = 1'b1;
        acc_n = 0; out_n = 0; cyc = 0; first_acc = 0; second_acc = 0; drop = 1'b0;
        while (cyc < 80 && !(out_n == 2 && acc_n == 2 && a_ready[0])) begin
            if (a_valid[0] && a_ready[0]) begin
                acc_n++;
                if (acc_n == 1) first_acc = cyc;
                if (acc_n == 2) begin
                    second_acc = cyc;
                    drop = 1'b1;
                end
            end
            if (o_valid[0] && o_ready[0]) begin
                out_n++;
                check("b2b data", o_data[0], 32'd285);
            end
            @(negedge clock);
            cyc++;
            if (drop) a_valid[0] = 1'b0;
        end
        a_valid[0] = 1'b0;
`ifdef TOP_CTRL_SYNC_EN
        period = 13;
`else
        period = 12;
`endif
        check("b2b accepts", 32'(acc_n), 32'd2);
        check("b2b results", 32'(out_n), 32'd2);
        check("b2b spacing", 32'(second_acc - first_acc), 32'(period));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter LOOP_COUNT, default 10: number of loop iterations; unsigned, 32-bit range.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 arg0_valid  input  1  start control token offered (no data payload).
REQ-005 arg0_ready  output  1  start token can be accepted.
REQ-006 out0_valid  output  1  result token valid.
REQ-007 out0_ready  input  1  consumer accepts result.
REQ-008 out0_data  output  32  result value.
REQ-009 outCtrl_valid  output  1  completion control token valid.
REQ-010 outCtrl_ready  input  1  consumer accepts completion token.

Function
REQ-011 Every channel SHALL use valid/ready; transfer occurs on a rising edge where valid and ready are both 1.
- Once valid is asserted, it SHALL stay asserted and data SHALL stay stable until transfer.
REQ-012 The block SHALL compute sum of i*i for i = 0 .. LOOP_COUNT-1, modulo 2^32; default result is 285.
REQ-013 State machine states: IDLE, RUN, DONE.
REQ-014 IDLE:
- arg0_ready = 1; all output valids = 0.
- On an arg0 transfer: set i = 0 and acc = 0, then enter RUN.
- If LOOP_COUNT == 0, enter DONE directly with acc = 0.
REQ-015 RUN:
- arg0_ready = 0.
- Each cycle: acc <= acc + i*i (32-bit multiply, truncated) and i <= i + 1.
- After the update with i == LOOP_COUNT-1, enter DONE.
- RUN SHALL last exactly LOOP_COUNT cycles.
REQ-016 DONE:
- out0_data = acc; out0_valid = 1 until its transfer; outCtrl_valid = 1 until its transfer.
- The two outputs handshake independently and may transfer in the same or in different cycles.
- After both have transferred, return to IDLE; arg0_ready SHALL be 1 in the next cycle.
REQ-017 arg0_valid asserted outside IDLE SHALL be ignored (not accepted, not queued).
REQ-018 out0_data SHALL hold acc in all states; its value is meaningful only while out0_valid = 1.
REQ-019 The block SHALL accept any number of consecutive tokens, one per IDLE visit, with identical results each time.

Reset
REQ-020 While reset = 1, outputs SHALL be: arg0_ready = 0, out0_valid = 0, outCtrl_valid = 0, out0_data = 0; state = IDLE, i = 0, acc = 0.
REQ-021 Reset asserted mid-RUN or mid-DONE SHALL abort the computation; no output token is produced for that start token.
REQ-022 In the first cycle after reset deasserts, arg0_ready SHALL be 1, and a token held over from reset SHALL be accepted at that edge.

Configuration
REQ-023 Macro TOP_CTRL_SYNC_EN controls ordering of the two completion tokens.
- Undefined: out0 and outCtrl behave per REQ-016.
- Defined: outCtrl_valid SHALL assert only in the cycle after the out0 transfer, forcing out0 before outCtrl.

Verification
REQ-024 Default params; arg0_valid = 1 during reset and for one cycle after; both readies = 1 -> single out0 transfer with out0_data = 285, outCtrl transfer; arg0_ready = 1 the cycle after return to IDLE.
REQ-025 LOOP_COUNT = 1 -> out0_data = 0; LOOP_COUNT = 0 -> out0_data = 0 with no RUN cycles; LOOP_COUNT = 4 -> 14.
REQ-026 Back-pressure: out0_ready = 0 for 5 cycles while outCtrl_ready = 1 -> outCtrl transfers at once, out0_valid holds with data 285, then out0 transfers; no return to IDLE before both transfers.
REQ-027 Reset pulsed during RUN, cycle 5 -> no output valid; next token -> 285 with correct latency (LOOP_COUNT RUN cycles).
REQ-028 Two back-to-back tokens, with arg0_valid held high throughout -> exactly two 285 results; arg0 not accepted during RUN or DONE.
REQ-029 TOP_CTRL_SYNC_EN defined, both readies = 1 -> outCtrl_valid rises exactly one cycle after the out0 transfer.
